// File: rtl/wb_trace_pkg.sv
// Shared types for the write-back trace buffer.
// Entry fields are sized to the widest supported build; instances use the low bits.
package wb_trace_pkg;

  localparam bit MODE_DROP      = 1'b0;
  localparam bit MODE_OVERWRITE = 1'b1;

  localparam int ENT_PC_MAX   = 64;
  localparam int ENT_REG_MAX  = 8;
  localparam int ENT_DATA_MAX = 64;
  localparam int ENT_CYC_MAX  = 64;

  typedef struct packed {
    logic [ENT_PC_MAX-1:0]   pc;
    logic [ENT_REG_MAX-1:0]  rd;
    logic [ENT_DATA_MAX-1:0] data;
    logic [ENT_CYC_MAX-1:0]  cyc;
  } trace_entry_t;

endpackage

// File: rtl/wb_trace_mem.sv
// Trace entry storage: one write port, one asynchronous read port.
// Contents are deliberately left unreset.
module wb_trace_mem
  import wb_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  trace_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output trace_entry_t rdata
);

  trace_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_buffer.sv
// Register write-back trace FIFO with drop/overwrite full policy,
// cycle timestamps and sticky loss accounting.
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int PC_W        = 32,
  parameter int CYC_W       = 32,
  parameter int DEPTH       = 16,
  parameter bit MODE        = MODE_DROP,
  parameter bit FILTER_ZERO = 1'b1,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trace_en,
  input  logic              clear,
  input  logic              reg_write,
  input  logic [REG_W-1:0]  write_reg,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PC_W-1:0]   pc,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [PC_W-1:0]   rd_pc,
  output logic [REG_W-1:0]  rd_reg,
  output logic [DATA_W-1:0] rd_data,
  output logic [CYC_W-1:0]  rd_cycle,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic [15:0]       drop_cnt,
  output logic [CYC_W-1:0]  cycle_cnt
);

  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic [15:0]      drops;
  logic [CYC_W-1:0] cyc;

  logic cap, full, pop, lose, we, rd_adv;
  trace_entry_t wentry, rentry;

  assign cap  = trace_en && reg_write &&
                !(FILTER_ZERO && (write_reg == '0));
  assign full = (cnt == CW'(DEPTH));
  assign pop  = (cnt != '0) && rd_ready;
  assign lose = cap && full && !pop;

  // Overwrite mode reuses the head slot, so the head moves with the tail.
  assign we     = !clear && cap &&
                  (!full || pop || (MODE == MODE_OVERWRITE));
  assign rd_adv = pop || (lose && (MODE == MODE_OVERWRITE));

  always_comb begin
    wentry = '0;
    wentry.pc[PC_W-1:0]     = pc;
    wentry.rd[REG_W-1:0]    = write_reg;
    wentry.data[DATA_W-1:0] = wr_data;
    wentry.cyc[CYC_W-1:0]   = cyc;
  end

  wb_trace_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wptr),
    .wdata (wentry),
    .raddr (rptr),
    .rdata (rentry)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      drops <= '0;
      cyc   <= '0;
    end else begin
      cyc <= cyc + CYC_W'(1);
      if (clear) begin
        wptr  <= '0;
        rptr  <= '0;
        cnt   <= '0;
        ovf   <= 1'b0;
        drops <= '0;
      end else begin
        if (we)     wptr <= wptr + AW'(1);
        if (rd_adv) rptr <= rptr + AW'(1);
        if (we && !rd_adv)      cnt <= cnt + CW'(1);
        else if (pop && !we)    cnt <= cnt - CW'(1);
        if (lose) begin
          ovf <= 1'b1;
          if (drops != 16'hFFFF) drops <= drops + 16'd1;
        end
      end
    end
  end

  assign rd_valid  = (cnt != '0);
  assign rd_pc     = rd_valid ? rentry.pc[PC_W-1:0]     : '0;
  assign rd_reg    = rd_valid ? rentry.rd[REG_W-1:0]    : '0;
  assign rd_data   = rd_valid ? rentry.data[DATA_W-1:0] : '0;
  assign rd_cycle  = rd_valid ? rentry.cyc[CYC_W-1:0]   : '0;
  assign count     = cnt;
  assign overflow  = ovf;
  assign drop_cnt  = drops;
  assign cycle_cnt = cyc;

  logic unused_bits;
  assign unused_bits = ^rentry;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: a drop-mode and an overwrite-mode instance
// share stimulus; expected entries come from per-instance scoreboard queues.
module tb_wb_trace_buffer;
  import wb_trace_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        trace_en = 1'b0;
  logic        clear = 1'b0;
  logic        reg_write = 1'b0;
  logic        rd_ready = 1'b0;
  logic [4:0]  write_reg = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] pc = '0;

  logic        d_valid, o_valid, d_ovf, o_ovf;
  logic [31:0] d_pc, o_pc, d_data, o_data, d_cyc, o_cyc;
  logic [31:0] d_cycle, o_cycle;
  logic [4:0]  d_reg, o_reg;
  logic [2:0]  d_count, o_count;
  logic [15:0] d_drop, o_drop;

  always #5 clk = ~clk;

  wb_trace_buffer #(.DEPTH(4), .MODE(MODE_DROP), .FILTER_ZERO(1'b1)) u_drop (
    .clk(clk), .reset(reset), .trace_en(trace_en), .clear(clear),
    .reg_write(reg_write), .write_reg(write_reg), .wr_data(wr_data),
    .pc(pc), .rd_ready(rd_ready), .rd_valid(d_valid), .rd_pc(d_pc),
    .rd_reg(d_reg), .rd_data(d_data), .rd_cycle(d_cyc), .count(d_count),
    .overflow(d_ovf), .drop_cnt(d_drop), .cycle_cnt(d_cycle)
  );

  wb_trace_buffer #(.DEPTH(4), .MODE(MODE_OVERWRITE), .FILTER_ZERO(1'b1)) u_ovw (
    .clk(clk), .reset(reset), .trace_en(trace_en), .clear(clear),
    .reg_write(reg_write), .write_reg(write_reg), .wr_data(wr_data),
    .pc(pc), .rd_ready(rd_ready), .rd_valid(o_valid), .rd_pc(o_pc),
    .rd_reg(o_reg), .rd_data(o_data), .rd_cycle(o_cyc), .count(o_count),
    .overflow(o_ovf), .drop_cnt(o_drop), .cycle_cnt(o_cycle)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  r;
    logic [31:0] d;
    logic [31:0] c;
  } ent_t;

  ent_t        qd[$];
  ent_t        qo[$];
  int          drd, dro;
  bit          ovd, ovo;
  logic [31:0] cyc_m;
  int          total, bad;

  task automatic model_flush();
    qd.delete();
    qo.delete();
    drd = 0;
    dro = 0;
    ovd = 0;
    ovo = 0;
  endtask

  task automatic step(input bit en, input bit wr, input logic [4:0] r,
                      input logic [31:0] d, input logic [31:0] p,
                      input bit rdy, input bit clr);
    ent_t e;
    bit   cap;
    trace_en  = en;
    reg_write = wr;
    write_reg = r;
    wr_data   = d;
    pc        = p;
    rd_ready  = rdy;
    clear     = clr;
    cap = en && wr && (r != 5'd0);
    e = '{pc: p, r: r, d: d, c: cyc_m};
    if (clr) begin
      model_flush();
    end else begin
      if (rdy && qd.size() > 0) qd.delete(0);
      if (rdy && qo.size() > 0) qo.delete(0);
      if (cap) begin
        if (qd.size() < 4) qd.push_back(e);
        else begin
          ovd = 1;
          if (drd < 65535) drd++;
        end
        if (qo.size() == 4) begin
          qo.delete(0);
          ovo = 1;
          if (dro < 65535) dro++;
        end
        qo.push_back(e);
      end
    end
    cyc_m++;
    @(posedge clk);
    #1;
    trace_en  = 0;
    reg_write = 0;
    rd_ready  = 0;
    clear     = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    #2;
    total++;
    if ({d_valid, d_count, d_ovf, d_drop, d_cycle, d_data} !==
        {1'b0, 3'd0, 1'b0, 16'd0, 32'd0, 32'd0}) begin
      bad++;
      $display("FAIL reset_drop got v=%b c=%0d o=%b dr=%0d cy=%0d d=%0h want all 0",
               d_valid, d_count, d_ovf, d_drop, d_cycle, d_data);
    end
    total++;
    if ({o_valid, o_count, o_ovf, o_drop, o_cycle, o_pc} !==
        {1'b0, 3'd0, 1'b0, 16'd0, 32'd0, 32'd0}) begin
      bad++;
      $display("FAIL reset_ovw got v=%b c=%0d o=%b dr=%0d cy=%0d pc=%0h want all 0",
               o_valid, o_count, o_ovf, o_drop, o_cycle, o_pc);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;
    cyc_m = 0;
    model_flush();
  endtask

  task automatic test_capture();
    step(1, 1, 5'd8, 32'd5, 32'd0, 0, 0);
    total++;
    if ({d_valid, d_reg, d_data, d_pc, d_cyc, d_count} !==
        {1'b1, 5'd8, 32'd5, 32'd0, 32'd0, 3'd1}) begin
      bad++;
      $display("FAIL capture got v=%b r=%0d d=%0d pc=%0d cy=%0d c=%0d want 1/8/5/0/0/1",
               d_valid, d_reg, d_data, d_pc, d_cyc, d_count);
    end
    total++;
    if (d_cycle !== cyc_m) begin
      bad++;
      $display("FAIL cycle_cnt got=%0d want=%0d", d_cycle, cyc_m);
    end
  endtask

  task automatic test_filter();
    step(0, 0, 5'd0, 32'd0, 32'd0, 0, 1);
    step(1, 1, 5'd0, 32'd7, 32'd4, 0, 0);
    step(0, 1, 5'd9, 32'd7, 32'd8, 0, 0);
    total++;
    if ({d_count, d_valid, d_data, o_count} !==
        {3'(qd.size()), 1'b0, 32'd0, 3'(qo.size())}) begin
      bad++;
      $display("FAIL filter got c=%0d v=%b d=%0h oc=%0d want 0/0/0/0",
               d_count, d_valid, d_data, o_count);
    end
  endtask

  task automatic test_full_policy();
    step(0, 0, 5'd0, 32'd0, 32'd0, 0, 1);
    for (int i = 1; i <= 6; i++)
      step(1, 1, 5'(i + 10), 32'(i), 32'(4 * i), 0, 0);
    total++;
    if ({d_count, d_ovf, d_drop} !== {3'(qd.size()), ovd, 16'(drd)}) begin
      bad++;
      $display("FAIL full_drop got c=%0d o=%b dr=%0d want %0d/%b/%0d",
               d_count, d_ovf, d_drop, qd.size(), ovd, drd);
    end
    total++;
    if ({o_count, o_ovf, o_drop} !== {3'(qo.size()), ovo, 16'(dro)}) begin
      bad++;
      $display("FAIL full_ovw got c=%0d o=%b dr=%0d want %0d/%b/%0d",
               o_count, o_ovf, o_drop, qo.size(), ovo, dro);
    end
    for (int k = 0; k < 4; k++) begin
      ent_t ed, eo;
      ed = qd[0];
      eo = qo[0];
      total++;
      if ({d_valid, d_data, d_pc, d_reg, d_cyc} !==
          {1'b1, ed.d, ed.pc, ed.r, ed.c}) begin
        bad++;
        $display("FAIL pop_drop[%0d] got d=%0d pc=%0d r=%0d cy=%0d want %0d/%0d/%0d/%0d",
                 k, d_data, d_pc, d_reg, d_cyc, ed.d, ed.pc, ed.r, ed.c);
      end
      total++;
      if ({o_valid, o_data, o_pc, o_reg, o_cyc} !==
          {1'b1, eo.d, eo.pc, eo.r, eo.c}) begin
        bad++;
        $display("FAIL pop_ovw[%0d] got d=%0d pc=%0d r=%0d cy=%0d want %0d/%0d/%0d/%0d",
                 k, o_data, o_pc, o_reg, o_cyc, eo.d, eo.pc, eo.r, eo.c);
      end
      step(0, 0, 5'd0, 32'd0, 32'd0, 1, 0);
    end
    total++;
    if ({d_valid, o_valid, d_count, o_count} !== {1'b0, 1'b0, 3'd0, 3'd0}) begin
      bad++;
      $display("FAIL drained got dv=%b ov=%b dc=%0d oc=%0d want 0/0/0/0",
               d_valid, o_valid, d_count, o_count);
    end
  endtask

  task automatic test_back_to_back();
    step(0, 0, 5'd0, 32'd0, 32'd0, 0, 1);
    for (int i = 0; i < 4; i++)
      step(1, 1, 5'd2, 32'(20 + i), 32'(100 + i), 0, 0);
    step(1, 1, 5'd3, 32'd30, 32'd200, 1, 0);
    total++;
    if ({d_count, d_drop, d_data, d_valid} !==
        {3'(qd.size()), 16'(drd), qd[0].d, 1'b1}) begin
      bad++;
      $display("FAIL full_pushpop_drop got c=%0d dr=%0d d=%0d want %0d/%0d/%0d",
               d_count, d_drop, d_data, qd.size(), drd, qd[0].d);
    end
    total++;
    if ({o_count, o_drop, o_data} !== {3'(qo.size()), 16'(dro), qo[0].d}) begin
      bad++;
      $display("FAIL full_pushpop_ovw got c=%0d dr=%0d d=%0d want %0d/%0d/%0d",
               o_count, o_drop, o_data, qo.size(), dro, qo[0].d);
    end
    step(1, 1, 5'd4, 32'd40, 32'd300, 1, 1);
    total++;
    if ({d_count, d_valid, o_count, o_valid} !== {3'd0, 1'b0, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL clear_push got dc=%0d dv=%b oc=%0d ov=%b want 0/0/0/0",
               d_count, d_valid, o_count, o_valid);
    end
    step(1, 1, 5'd5, 32'd50, 32'd400, 1, 0);
    total++;
    if ({d_count, d_data, o_count, o_data} !==
        {3'(qd.size()), qd[0].d, 3'(qo.size()), qo[0].d}) begin
      bad++;
      $display("FAIL empty_pushpop got dc=%0d dd=%0d oc=%0d od=%0d want 1/50",
               d_count, d_data, o_count, o_data);
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 5'd0, 32'd0, 32'd0, 0, 1);
    for (int i = 0; i < 3; i++)
      step(1, 1, 5'd6, 32'(60 + i), 32'(500 + i), 0, 0);
    total++;
    if ({d_count, o_count} !== {3'(qd.size()), 3'(qo.size())}) begin
      bad++;
      $display("FAIL pre_reset got dc=%0d oc=%0d want 3/3", d_count, o_count);
    end
    #2;
    reset = 0;
    #1;
    total++;
    if ({d_valid, d_count, d_cycle, d_data, o_valid, o_count, o_cycle} !==
        {1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0}) begin
      bad++;
      $display("FAIL async_reset got dv=%b dc=%0d dcy=%0d dd=%0h ov=%b oc=%0d ocy=%0d want 0",
               d_valid, d_count, d_cycle, d_data, o_valid, o_count, o_cycle);
    end
    model_flush();
    @(negedge clk);
    reset = 1;
    cyc_m = 0;
    step(1, 1, 5'd3, 32'd77, 32'd100, 0, 0);
    total++;
    if ({d_cyc, d_data, d_count, d_cycle, o_cyc} !==
        {qd[0].c, qd[0].d, 3'(qd.size()), cyc_m, qo[0].c}) begin
      bad++;
      $display("FAIL post_reset got ts=%0d d=%0d c=%0d cy=%0d ots=%0d want 0/77/1/1/0",
               d_cyc, d_data, d_count, d_cycle, o_cyc);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc_m = 0;
    model_flush();
    test_reset();
    test_capture();
    test_filter();
    test_full_policy();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
